chunk_mult_seq: RTL and testbench

- Parametrised sequential multiplier and controller; successor to the fixed 4-state 8x8 shift-add controller.
- Splits WIDTH-bit unsigned operands into CHUNK-bit chunks and multiplies one chunk pair per cycle with a CHUNK x CHUNK multiplier.
- Shifts each partial product and accumulates it.
- Owns its own chunk counters and a start/busy/done handshake; no external count input.
- Adds synchronous abort and back-to-back operation.

---
 rtl/chunk_mult_pkg.sv | 21 ++
 rtl/chunk_mult_seq_if.sv | 34 +++
 rtl/chunk_mult_fsm.sv | 94 +++++++++
 rtl/chunk_mult_seq.sv | 94 +++++++++
 tb/tb_chunk_mult_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/chunk_mult_pkg.sv
// Shared types and helpers for the chunked sequential multiplier.
package chunk_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a counter over n values; never narrower than one bit so
  // the single-chunk configuration still has legal index ports.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit position of the partial product for chunk pair (idx_a, idx_b).
  function automatic int chunk_shift(input int idx_a, input int idx_b, input int chunk);
    return (idx_a + idx_b) * chunk;
  endfunction

endpackage

// File: rtl/chunk_mult_seq_if.sv
// Request/response bundle of the chunked multiplier. The master side issues
// operands and start/abort; the slave side returns the product and status.
interface chunk_mult_seq_if
  import chunk_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = clog2_min1(NCH);

  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;
  logic                 done;
  logic [1:0]           state;
  logic [IDXW-1:0]      idx_a;
  logic [IDXW-1:0]      idx_b;

  modport master (
    output start, abort, a, b,
    input  result, busy, done, state, idx_a, idx_b
  );

  modport slave (
    input  start, abort, a, b,
    output result, busy, done, state, idx_a, idx_b
  );

endinterface

// File: rtl/chunk_mult_fsm.sv
// Controller for the chunked multiplier: state register, chunk-pair
// counters (b inner, a outer, both descending) and last-pair detection.
module chunk_mult_fsm
  import chunk_mult_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int IDXW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            load,
  output logic            acc_en,
  output logic            finish,
  output logic            busy,
  output logic            done,
  output state_t          state,
  output logic [IDXW-1:0] idx_a,
  output logic [IDXW-1:0] idx_b
);

  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCH - 1);

  state_t          next_state;
  logic [IDXW-1:0] next_idx_a;
  logic [IDXW-1:0] next_idx_b;
  logic            last_pair;

  assign last_pair = (idx_a == '0) && (idx_b == '0);

  // Status flags are decoded from the registered state only.
  assign busy = (state == MUL);
  assign done = (state == DONE);

  // Register the state and chunk counters; reset returns to IDLE at pair 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx_a <= '0;
      idx_b <= '0;
    end else begin
      state <= next_state;
      idx_a <= next_idx_a;
      idx_b <= next_idx_b;
    end
  end

  // Next-state and datapath strobes; abort wins over completion in MUL.
  always_comb begin
    next_state = state;
    next_idx_a = idx_a;
    next_idx_b = idx_b;
    load       = 1'b0;
    acc_en     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = MUL;
          next_idx_a = TOP_IDX;
          next_idx_b = TOP_IDX;
        end else begin
          next_state = IDLE;
        end
      end
      MUL: begin
        if (abort) begin
          next_state = IDLE;
          next_idx_a = '0;
          next_idx_b = '0;
        end else begin
          acc_en = 1'b1;
          if (last_pair) begin
            finish     = 1'b1;
            next_state = DONE;
          end else if (idx_b == '0) begin
            next_idx_b = TOP_IDX;
            next_idx_a = idx_a - 1'b1;
          end else begin
            next_idx_b = idx_b - 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_idx_a = '0;
        next_idx_b = '0;
      end
    endcase
  end

endmodule

// File: rtl/chunk_mult_seq.sv
// Sequential unsigned multiplier: WIDTH-bit operands are split into CHUNK-bit
// pieces and one chunk pair is multiplied and accumulated per cycle.
// WIDTH must be a multiple of CHUNK.
module chunk_mult_seq
  import chunk_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  chunk_mult_seq_if.slave bus
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = clog2_min1(NCH);
  localparam int PW   = 2 * WIDTH;

  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     result_reg;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]     pp_shifted;
  logic [PW-1:0]     acc_sum;

  logic              load;
  logic              acc_en;
  logic              finish;
  logic              busy;
  logic              done;
  state_t            state;
  logic [IDXW-1:0]   idx_a;
  logic [IDXW-1:0]   idx_b;

  chunk_mult_fsm #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.start),
    .abort  (bus.abort),
    .load   (load),
    .acc_en (acc_en),
    .finish (finish),
    .busy   (busy),
    .done   (done),
    .state  (state),
    .idx_a  (idx_a),
    .idx_b  (idx_b)
  );

  // Select the current chunk pair, multiply it and move it into place.
  always_comb begin
    a_chunk    = a_reg[int'(idx_a) * CHUNK +: CHUNK];
    b_chunk    = b_reg[int'(idx_b) * CHUNK +: CHUNK];
    pp         = (2*CHUNK)'(a_chunk) * (2*CHUNK)'(b_chunk);
    pp_shifted = PW'(pp) << chunk_shift(int'(idx_a), int'(idx_b), CHUNK);
    acc_sum    = acc + pp_shifted;
  end

  // Operand capture, accumulation and the result register that only moves
  // when the final pair completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      result_reg <= '0;
    end else begin
      if (load) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        acc   <= '0;
      end else if (acc_en) begin
        acc <= acc_sum;
      end
      if (finish) begin
        result_reg <= acc_sum;
      end
    end
  end

  assign bus.result = result_reg;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.state  = state;
  assign bus.idx_a  = idx_a;
  assign bus.idx_b  = idx_b;

endmodule

// File: tb/tb_chunk_mult_seq.sv
// Directed bench for chunk_mult_seq in the 8/4, 16/4 and 8/8 configurations.
module tb_chunk_mult_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  chunk_mult_seq_if #(.WIDTH(8),  .CHUNK(4)) if84  ();
  chunk_mult_seq_if #(.WIDTH(16), .CHUNK(4)) if164 ();
  chunk_mult_seq_if #(.WIDTH(8),  .CHUNK(8)) if88  ();

  chunk_mult_seq #(.WIDTH(8),  .CHUNK(4)) dut84  (.clk(clk), .rst(rst), .bus(if84.slave));
  chunk_mult_seq #(.WIDTH(16), .CHUNK(4)) dut164 (.clk(clk), .rst(rst), .bus(if164.slave));
  chunk_mult_seq #(.WIDTH(8),  .CHUNK(8)) dut88  (.clk(clk), .rst(rst), .bus(if88.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset state of every configuration while rst is held low.
  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if84.result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0000", if84.result); end
    checks++;
    if ({if84.busy, if84.done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_done: got %b expected 00", {if84.busy, if84.done}); end
    checks++;
    if (if84.state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", if84.state); end
    checks++;
    if ({if84.idx_a, if84.idx_b} !== 2'b00) begin errors++; $display("[TB] FAIL reset_idx: got %b expected 00", {if84.idx_a, if84.idx_b}); end
    checks++;
    if (if164.result !== 32'h0 || if88.result !== 16'h0) begin errors++; $display("[TB] FAIL reset_other: got %h/%h expected 0/0", if164.result, if88.result); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // 0xFF * 0xFF: busy four cycles with MSB-first index order, then done.
  task automatic test_basic();
    logic [3:0] exp_idx [4];
    exp_idx[0] = 4'b01_01; exp_idx[1] = 4'b01_00; exp_idx[2] = 4'b00_01; exp_idx[3] = 4'b00_00;
    if84.a = 8'hFF; if84.b = 8'hFF; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({if84.busy, if84.done, if84.state} !== 4'b10_01) begin
        errors++; $display("[TB] FAIL basic_busy[%0d]: got busy=%b done=%b state=%0d expected 1/0/1", i, if84.busy, if84.done, if84.state);
      end
      checks++;
      if ({2'b00, if84.idx_a, 1'b0, if84.idx_b} !== exp_idx[i]) begin
        errors++; $display("[TB] FAIL basic_idx[%0d]: got (%0d,%0d) expected %b", i, if84.idx_a, if84.idx_b, exp_idx[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({if84.busy, if84.done, if84.state} !== 4'b01_10) begin
      errors++; $display("[TB] FAIL basic_done: got busy=%b done=%b state=%0d expected 0/1/2", if84.busy, if84.done, if84.state);
    end
    checks++;
    if (if84.result !== 16'hFE01) begin errors++; $display("[TB] FAIL basic_result: got %h expected FE01", if84.result); end
  endtask

  // New start issued in the DONE cycle goes straight back to MUL.
  task automatic test_back_to_back();
    if84.a = 8'h12; if84.b = 8'h34; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    checks++;
    if ({if84.busy, if84.done, if84.state} !== 4'b10_01) begin
      errors++; $display("[TB] FAIL b2b_no_bubble: got busy=%b done=%b state=%0d expected 1/0/1", if84.busy, if84.done, if84.state);
    end
    checks++;
    if (if84.result !== 16'hFE01) begin errors++; $display("[TB] FAIL b2b_result_hold: got %h expected FE01", if84.result); end
    repeat (3) @(negedge clk);
    checks++;
    if (if84.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_done: got %b expected 0", if84.done); end
    @(negedge clk);
    checks++;
    if (if84.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got %b expected 1", if84.done); end
    checks++;
    if (if84.result !== 16'h03A8) begin errors++; $display("[TB] FAIL b2b_result: got %h expected 03A8", if84.result); end
    @(negedge clk);
    checks++;
    if ({if84.done, if84.state} !== 3'b0_00) begin errors++; $display("[TB] FAIL b2b_pulse_len: got done=%b state=%0d expected 0/0", if84.done, if84.state); end
  endtask

  // Abort on the final MUL cycle suppresses completion and keeps result.
  task automatic test_abort();
    if84.a = 8'hAA; if84.b = 8'h55; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    repeat (3) @(negedge clk);
    if84.abort = 1'b1;
    @(negedge clk);
    if84.abort = 1'b0;
    checks++;
    if ({if84.busy, if84.done, if84.state} !== 4'b00_00) begin
      errors++; $display("[TB] FAIL abort_state: got busy=%b done=%b state=%0d expected 0/0/0", if84.busy, if84.done, if84.state);
    end
    checks++;
    if (if84.result !== 16'h03A8) begin errors++; $display("[TB] FAIL abort_result: got %h expected 03A8", if84.result); end
    @(negedge clk);
    checks++;
    if (if84.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_late_done: got %b expected 0", if84.done); end
  endtask

  // start with new operands during MUL must not disturb the running product.
  task automatic test_start_ignored();
    if84.a = 8'h0F; if84.b = 8'h0F; if84.start = 1'b1;
    @(negedge clk);
    if84.a = 8'h01; if84.b = 8'h01;
    repeat (3) @(negedge clk);
    if84.start = 1'b0;
    @(negedge clk);
    checks++;
    if (if84.done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done: got %b expected 1", if84.done); end
    checks++;
    if (if84.result !== 16'h00E1) begin errors++; $display("[TB] FAIL ignore_result: got %h expected 00E1", if84.result); end
    @(negedge clk);
  endtask

  // Asynchronous reset mid-operation, then a clean product afterwards.
  task automatic test_reset_mid();
    if84.a = 8'h33; if84.b = 8'h44; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if84.busy, if84.done, if84.state, if84.idx_a, if84.idx_b} !== 6'b0) begin
      errors++; $display("[TB] FAIL midrst_status: got busy=%b done=%b state=%0d idx=(%0d,%0d) expected all 0", if84.busy, if84.done, if84.state, if84.idx_a, if84.idx_b);
    end
    checks++;
    if (if84.result !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_result: got %h expected 0000", if84.result); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if84.a = 8'h03; if84.b = 8'h05; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if84.done, if84.result} !== {1'b1, 16'h000F}) begin
      errors++; $display("[TB] FAIL midrst_restart: got done=%b result=%h expected 1/000F", if84.done, if84.result);
    end
    @(negedge clk);
  endtask

  // 16/4 configuration: sixteen MUL cycles starting at pair (3,3).
  task automatic test_wide();
    int busy_bad;
    busy_bad = 0;
    if164.a = 16'hFFFF; if164.b = 16'hFFFF; if164.start = 1'b1;
    @(negedge clk);
    if164.start = 1'b0;
    checks++;
    if ({if164.idx_a, if164.idx_b} !== 4'b11_11) begin
      errors++; $display("[TB] FAIL wide_first_idx: got (%0d,%0d) expected (3,3)", if164.idx_a, if164.idx_b);
    end
    for (int i = 0; i < 15; i++) begin
      if (if164.busy !== 1'b1 || if164.done !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("[TB] FAIL wide_busy: got %0d bad cycles expected 0", busy_bad); end
    @(negedge clk);
    checks++;
    if ({if164.done, if164.busy} !== 2'b10) begin errors++; $display("[TB] FAIL wide_done: got done=%b busy=%b expected 1/0", if164.done, if164.busy); end
    checks++;
    if (if164.result !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL wide_result: got %h expected FFFE0001", if164.result); end
    @(negedge clk);
  endtask

  // CHUNK==WIDTH: one MUL cycle, indices stay zero.
  task automatic test_single_chunk();
    if88.a = 8'h80; if88.b = 8'h02; if88.start = 1'b1;
    @(negedge clk);
    if88.start = 1'b0;
    checks++;
    if ({if88.busy, if88.state, if88.idx_a, if88.idx_b} !== 5'b1_01_0_0) begin
      errors++; $display("[TB] FAIL single_mul: got busy=%b state=%0d idx=(%0d,%0d) expected 1/1/(0,0)", if88.busy, if88.state, if88.idx_a, if88.idx_b);
    end
    @(negedge clk);
    checks++;
    if ({if88.done, if88.result} !== {1'b1, 16'h0100}) begin
      errors++; $display("[TB] FAIL single_result: got done=%b result=%h expected 1/0100", if88.done, if88.result);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    if84.start = 1'b0;  if84.abort = 1'b0;  if84.a = '0;  if84.b = '0;
    if164.start = 1'b0; if164.abort = 1'b0; if164.a = '0; if164.b = '0;
    if88.start = 1'b0;  if88.abort = 1'b0;  if88.a = '0;  if88.b = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_wide();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
